// File: rtl/ctc_int_ctrl_if.sv
// Z80-side bus bundle for the CTC interrupt controller: cycle strobes, data, daisy chain, int_n.
// master is the CPU/bus side, slave is the controller.
interface ctc_int_ctrl_if #(
  parameter int unsigned DWID = 8
);
  logic            m1_n;
  logic            iorq_n;
  logic            mreq_n;
  logic            rd_n;
  logic [DWID-1:0] din;
  logic [DWID-1:0] dout;
  logic            oe_n;
  logic            iei;
  logic            ieo;
  logic            int_n;

  modport master (
    output m1_n, iorq_n, mreq_n, rd_n, din, iei,
    input  dout, oe_n, ieo, int_n
  );

  modport slave (
    input  m1_n, iorq_n, mreq_n, rd_n, din, iei,
    output dout, oe_n, ieo, int_n
  );
endinterface

// File: rtl/ctc_int_ctrl.sv
// Interrupt controller for a Z80 CTC: edge-captured channel requests, mode-2 vector on INTA,
// IEI/IEO daisy chain and RETI (ED 4D) detection to end service.
module ctc_int_ctrl #(
  parameter int unsigned DWID = 8,
  parameter int unsigned NCH  = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NCH-1:0]  zc_to,
  input  logic [NCH-1:0]  int_en,
  input  logic [NCH-1:0]  chan_reset,
  input  logic            vec_wr,
  ctc_int_ctrl_if.slave   bus,
  output logic [NCH-1:0]  in_service
);

  typedef enum logic [0:0] {StIdle, StSawEd} reti_st_e;

  reti_st_e        state_q, state_d;
  logic [NCH-1:0]  zc_q;
  logic [NCH-1:0]  pending_q, pending_d;
  logic [NCH-1:0]  in_service_q, in_service_d;
  logic [4:0]      base_q, base_d;
  logic            inta_q, fetch_q;
  logic [DWID-1:0] dout_q, dout_d;
  logic            oe_n_q, oe_n_d;
  logic            int_n_q, int_n_d;
  logic            ieo_q, ieo_d;

  logic            inta, inta_start, fetch, fetch_start;
  logic            ack, reti;
  logic [1:0]      ack_idx;
  logic [NCH-1:0]  ack_oh, reti_oh, ack_mask, reti_mask, set_req;
  logic [7:0]      vector;

  // Lowest-index pending channel wins the acknowledge; lowest in-service channel takes RETI.
  always_comb begin
    ack_idx = '0;
    ack_oh  = '0;
    reti_oh = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        ack_idx    = 2'(i);
        ack_oh     = '0;
        ack_oh[i]  = 1'b1;
      end
      if (in_service_q[i]) begin
        reti_oh    = '0;
        reti_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    reti    = 1'b0;
    if (fetch_start) begin
      unique case (state_q)
        StIdle: begin
          if (bus.din[7:0] == 8'hED) state_d = StSawEd;
        end
        StSawEd: begin
          if (bus.din[7:0] == 8'h4D) begin
            reti    = 1'b1;
            state_d = StIdle;
          end else if (bus.din[7:0] != 8'hED) begin
            state_d = StIdle;
          end
        end
      endcase
    end
  end

  always_comb begin
    inta        = !bus.m1_n && !bus.iorq_n;
    inta_start  = inta && !inta_q;
    fetch       = !bus.m1_n && !bus.mreq_n && !bus.rd_n;
    fetch_start = fetch && !fetch_q;

    ack       = inta_start && bus.iei && !(|in_service_q) && (|pending_q);
    ack_mask  = ack ? ack_oh : '0;
    reti_mask = (reti && bus.iei) ? reti_oh : '0;
    vector    = {base_q, ack_idx, 1'b0};

    // A new edge in the acknowledge clock survives the ack clear, so it is served after RETI.
    set_req      = zc_to & ~zc_q & int_en & ~chan_reset;
    pending_d    = ((pending_q & ~ack_mask) | set_req) & int_en & ~chan_reset;
    in_service_d = (in_service_q | ack_mask) & ~reti_mask;
    base_d       = vec_wr ? bus.din[7:3] : base_q;

    dout_d  = ack ? DWID'(vector) : '0;
    oe_n_d  = !ack;
    int_n_d = !(bus.iei && (|pending_q) && !(|in_service_q));
    ieo_d   = bus.iei && !(|in_service_q) && !((|pending_q) && !bus.m1_n);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      zc_q         <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      base_q       <= '0;
      inta_q       <= 1'b0;
      fetch_q      <= 1'b0;
      dout_q       <= '0;
      oe_n_q       <= 1'b1;
      int_n_q      <= 1'b1;
      ieo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      zc_q         <= zc_to;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      base_q       <= base_d;
      inta_q       <= inta;
      fetch_q      <= fetch;
      dout_q       <= dout_d;
      oe_n_q       <= oe_n_d;
      int_n_q      <= int_n_d;
      ieo_q        <= ieo_d;
    end
  end

  assign bus.dout   = dout_q;
  assign bus.oe_n   = oe_n_q;
  assign bus.int_n  = int_n_q;
  assign bus.ieo    = ieo_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_ctc_int_ctrl.sv
// Self-checking bench for ctc_int_ctrl: expected vectors are queued at INTA and popped
// whenever the DUT drives oe_n low.
module tb_ctc_int_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] zc_to, int_en, chan_reset, in_service;
  logic       vec_wr;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  sb_q[$];

  ctc_int_ctrl_if #(.DWID(8)) bus ();

  ctc_int_ctrl #(.DWID(8), .NCH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .zc_to      (zc_to),
    .int_en     (int_en),
    .chan_reset (chan_reset),
    .vec_wr     (vec_wr),
    .bus        (bus),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every oe_n-low cycle must match the oldest queued vector.
  always @(negedge clk) begin
    if (bus.oe_n === 1'b0) begin
      if (sb_q.size() == 0) check("oe_spurious", 32'(bus.oe_n), 32'd1);
      else                  check("vector", 32'(bus.dout), 32'(sb_q.pop_front()));
    end
  end

  task automatic inta(input bit exp_vld, input logic [7:0] exp_vec);
    if (exp_vld) sb_q.push_back(exp_vec);
    bus.m1_n   = 1'b0;
    bus.iorq_n = 1'b0;
    tick(2);
    bus.m1_n   = 1'b1;
    bus.iorq_n = 1'b1;
    tick(2);
    check("inta_drain", sb_q.size(), 0);
  endtask

  task automatic fetch(input logic [7:0] op);
    bus.din    = op;
    bus.m1_n   = 1'b0;
    bus.mreq_n = 1'b0;
    bus.rd_n   = 1'b0;
    tick(1);
    bus.m1_n   = 1'b1;
    bus.mreq_n = 1'b1;
    bus.rd_n   = 1'b1;
    bus.din    = 8'h00;
    tick(1);
  endtask

  task automatic reti_seq();
    fetch(8'hED);
    fetch(8'h4D);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    zc_to      = '0;
    int_en     = 4'hF;
    chan_reset = '0;
    vec_wr     = 1'b0;
    bus.m1_n   = 1'b1;
    bus.iorq_n = 1'b1;
    bus.mreq_n = 1'b1;
    bus.rd_n   = 1'b1;
    bus.din    = 8'h00;
    bus.iei    = 1'b1;
    tick(3);
    check("rst_dout", 32'(bus.dout), 0);
    check("rst_oe_n", 32'(bus.oe_n), 1);
    check("rst_int_n", 32'(bus.int_n), 1);
    check("rst_ieo", 32'(bus.ieo), 0);
    check("rst_in_service", 32'(in_service), 0);
    reset_n = 1'b1;

    // Base 0x10, single request on channel 2.
    vec_wr  = 1'b1;
    bus.din = 8'h80;
    tick(1);
    vec_wr  = 1'b0;
    bus.din = 8'h00;
    check("ieo_idle", 32'(bus.ieo), 1);
    zc_to = 4'b0100;
    tick(1);
    check("int_n_lat1", 32'(bus.int_n), 1);
    tick(1);
    check("int_n_lat2", 32'(bus.int_n), 0);
    inta(1'b1, 8'h84);
    check("svc_ch2", 32'(in_service), 32'h4);
    check("int_n_svc", 32'(bus.int_n), 1);
    check("ieo_svc", 32'(bus.ieo), 0);
    zc_to = '0;
    reti_seq();
    check("reti_ch2", 32'(in_service), 0);

    // Channels 1 and 3 together: priority then RETI hand-over.
    zc_to = 4'b1010;
    tick(2);
    check("int_n_two", 32'(bus.int_n), 0);
    inta(1'b1, 8'h82);
    check("svc_ch1", 32'(in_service), 32'h2);
    reti_seq();
    tick(1);
    check("reti_ch1", 32'(in_service), 0);
    check("int_n_ch3", 32'(bus.int_n), 0);
    inta(1'b1, 8'h86);
    check("svc_ch3", 32'(in_service), 32'h8);
    reti_seq();
    check("reti_ch3", 32'(in_service), 0);
    zc_to = '0;
    tick(1);

    // iei low blocks request and acknowledge.
    bus.iei = 1'b0;
    zc_to   = 4'b0001;
    tick(3);
    check("int_n_iei0", 32'(bus.int_n), 1);
    inta(1'b0, 8'h00);
    check("dout_iei0", 32'(bus.dout), 0);
    check("oe_n_iei0", 32'(bus.oe_n), 1);
    bus.iei = 1'b1;
    tick(1);
    check("int_n_iei1", 32'(bus.int_n), 0);
    inta(1'b1, 8'h80);
    check("svc_ch0", 32'(in_service), 32'h1);

    // Broken and repeated-ED RETI sequences.
    fetch(8'hED);
    fetch(8'h00);
    fetch(8'h4D);
    check("reti_broken", 32'(in_service), 32'h1);
    fetch(8'hED);
    fetch(8'hED);
    fetch(8'h4D);
    check("reti_eded", 32'(in_service), 0);

    // chan_reset drops a pending request; a held level fires only once.
    zc_to = '0;
    tick(1);
    zc_to = 4'b0001;
    tick(1);
    chan_reset = 4'b0001;
    tick(1);
    chan_reset = '0;
    tick(2);
    check("int_n_chrst", 32'(bus.int_n), 1);
    inta(1'b0, 8'h00);
    zc_to = '0;
    tick(1);
    zc_to = 4'b0001;
    tick(2);
    check("int_n_hold", 32'(bus.int_n), 0);
    tick(98);
    inta(1'b1, 8'h80);
    reti_seq();
    tick(3);
    check("hold_svc", 32'(in_service), 0);
    check("hold_once", 32'(bus.int_n), 1);
    inta(1'b0, 8'h00);
    zc_to = '0;
    tick(1);

    // Reset between ED and 4D.
    fetch(8'hED);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check("mid_dout", 32'(bus.dout), 0);
    check("mid_oe_n", 32'(bus.oe_n), 1);
    check("mid_int_n", 32'(bus.int_n), 1);
    check("mid_ieo", 32'(bus.ieo), 0);
    check("mid_in_service", 32'(in_service), 0);
    zc_to = 4'b0010;
    tick(2);
    inta(1'b1, 8'h02);
    check("svc_base0", 32'(in_service), 32'h2);
    fetch(8'h4D);
    tick(1);
    check("lone_4d", 32'(in_service), 32'h2);
    reti_seq();
    check("reti_base0", 32'(in_service), 0);
    zc_to = '0;
    tick(1);

    // vec_wr and a fresh channel-0 edge in the INTA clock.
    vec_wr  = 1'b1;
    bus.din = 8'h80;
    tick(1);
    vec_wr  = 1'b0;
    zc_to   = 4'b0001;
    tick(2);
    zc_to   = '0;
    tick(1);
    sb_q.push_back(8'h80);
    zc_to      = 4'b0001;
    vec_wr     = 1'b1;
    bus.din    = 8'hF8;
    bus.m1_n   = 1'b0;
    bus.iorq_n = 1'b0;
    tick(1);
    vec_wr     = 1'b0;
    bus.din    = 8'h00;
    tick(1);
    bus.m1_n   = 1'b1;
    bus.iorq_n = 1'b1;
    tick(2);
    check("old_base_drain", sb_q.size(), 0);
    check("svc_set_win", 32'(in_service), 32'h1);
    reti_seq();
    tick(1);
    check("int_n_set_win", 32'(bus.int_n), 0);
    inta(1'b1, 8'hF8);
    check("svc_new_base", 32'(in_service), 32'h1);
    reti_seq();
    check("reti_final", 32'(in_service), 0);

    tick(2);
    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ctc_int_ctrl.md
Name: ctc_int_ctrl

Overview:
- Interrupt controller for a 4-channel Z80 CTC; sits directly downstream of the per-channel counter/timer cores.
- Converts each channel's zero-count/timeout output into an interrupt request and drives int_n.
- Answers the Z80 mode-2 interrupt acknowledge with a vector.
- Takes part in the IEI/IEO daisy chain and detects RETI (ED 4D) to end service.

Parameters:
- DWID, 8, data bus width. Only 8 is supported.
- NCH, 4, number of channels, 1..4. Channel 0 has the highest priority.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- zc_to  in  NCH  per-channel zero-count/timeout level from the channel cores
- int_en  in  NCH  per-channel interrupt enable (CCW bit 7)
- chan_reset  in  NCH  per-channel software reset level (CCW bit 1)
- vec_wr  in  1  one-cycle strobe: load vector base from din[7:3]
- m1_n  in  1  Z80 M1
- iorq_n  in  1  Z80 IORQ
- mreq_n  in  1  Z80 MREQ
- rd_n  in  1  Z80 RD
- din  in  DWID  Z80 data bus in
- dout  out  DWID  vector output; 0 when not driving
- oe_n  out  1  low for the one cycle in which dout is valid
- iei  in  1  daisy-chain enable in
- ieo  out  1  daisy-chain enable out
- int_n  out  1  interrupt request, active low
- in_service  out  NCH  per-channel under-service flags

Behaviour:
- Clock and reset:
  - One clock (clk). Reset is synchronous and active-low (reset_n); all state is updated on posedge clk.
  - Reset values: dout=0, oe_n=1, int_n=1, ieo=0, in_service=0, pending=0, vector base=0, RETI FSM=IDLE, all edge-detect registers=0.
- Request capture:
  - zc_to is registered. A rising edge on channel i with int_en[i]=1 and chan_reset[i]=0 sets pending[i] on the next clock.
  - A level held high does not re-trigger.
- Clearing pending:
  - chan_reset[i]=1 clears pending[i]; it does not clear in_service[i].
  - int_en[i]=0 also clears pending[i].
- Vector base: vec_wr=1 loads base <= din[7:3]. The vector is {base, chan[1:0], 1'b0}.
- int_n:
  - Registered; low when iei=1, any pending bit is set, and no channel is in service.
  - Latency from zc_to edge to int_n low is 2 clocks.
- ieo:
  - Registered: ieo = iei && !(|in_service) && !((|pending) && !m1_n).
- Interrupt acknowledge (INTA):
  - INTA = !m1_n && !iorq_n. It is edge-detected; only the first clock of INTA acts.
  - On that clock, if iei=1, no channel is in service, and any pending bit is set:
    - pick k = lowest-index pending channel;
    - drive dout=vector(k) and oe_n=0 for exactly one clock;
    - clear pending[k] and set in_service[k].
  - Otherwise dout stays 0 and oe_n stays 1.
- Simultaneous events:
  - A zc_to edge on channel k in the same clock as its acknowledge: pending[k] ends set (set wins). The new request is served after RETI.
  - vec_wr in the same clock as INTA: the vector uses the old base.
- RETI detection:
  - Opcode fetch = !m1_n && !mreq_n && !rd_n, edge-detected. Opcode bytes are sampled from din on the first clock of the fetch.
  - RETI FSM states:
    - IDLE: fetch of 0xED -> SAW_ED.
    - SAW_ED: fetch of 0x4D -> RETI action, then IDLE. Fetch of 0xED -> stay in SAW_ED. Any other fetch -> IDLE.
  - Non-M1 cycles do not change FSM state.
  - RETI action: if iei=1, clear the in_service bit of the lowest-index channel in service. If iei=0, no change.
- Reset mid-operation: reset_n low during INTA or between ED and 4D returns to the reset values; a later 4D alone does nothing.
- NCH<4: channel codes above NCH-1 are never produced.

Test Plan:
- base=0x10 (vec_wr, din=0x80), int_en=4'hF, zc_to[2] rises, iei=1 -> int_n low 2 clocks later; INTA -> dout=0x84 with oe_n=0 for 1 clock; in_service=4'b0100; int_n high; ieo=0.
- zc_to[1] and zc_to[3] rise in the same clock; INTA -> dout=0x82; fetch ED, 4D -> in_service=0; int_n low again; second INTA -> dout=0x86.
- iei=0 with channel 0 pending -> int_n stays 1; INTA -> oe_n stays 1, dout=0; set iei=1 -> int_n low on the next clock.
- Fetch ED, 00, 4D while channel 0 in service -> in_service unchanged. Fetch ED, ED, 4D -> channel 0 cleared.
- chan_reset[0] pulsed while pending[0]=1 -> int_n returns to 1 with no vector on a following INTA. zc_to[0] held high for 100 clocks -> only one request.
- reset_n low for 1 clock after ED is fetched -> all outputs at reset values; then fetching 4D alone -> in_service unchanged.
